// File: rtl/flush_hazard_ctrl.sv
// flush_hazard_ctrl: prioritised pipeline flush/stall controller with redirect hold, exception drain and flush counter
module flush_hazard_ctrl #(
  parameter int STAGES    = 4,
  parameter int BR_STAGE  = 2,
  parameter int JMP_STAGE = 1,
  parameter int DRAIN_CYC = 2,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              branch_taken,
  input  logic              jump,
  input  logic              exc_req,
  input  logic              load_use,
  input  logic              mem_busy,
  input  logic              cnt_clr,
  output logic [STAGES-1:0] flush,
  output logic              stall_front,
  output logic [1:0]        pc_sel,
  output logic              busy,
  output logic [CNT_W-1:0]  flush_count
);
  localparam int DW = $clog2(DRAIN_CYC + 1);
  localparam logic [STAGES-1:0] ALL    = {STAGES{1'b1}};
  localparam logic [STAGES-1:0] BR_M   = ALL >> (STAGES - BR_STAGE);
  localparam logic [STAGES-1:0] JMP_M  = ALL >> (STAGES - JMP_STAGE);
  localparam logic [STAGES-1:0] BUBBLE = STAGES'(2);
  localparam logic [1:0] K_NONE = 2'd0, K_BR = 2'd1, K_JMP = 2'd2, K_EXC = 2'd3;
  if (STAGES < 2 || BR_STAGE < 1 || BR_STAGE > STAGES || JMP_STAGE < 1 ||
      JMP_STAGE > BR_STAGE || DRAIN_CYC < 1 || CNT_W < 1) begin : g_bad_param
    $error("flush_hazard_ctrl: illegal parameter combination");
  end
  typedef enum logic [1:0] {RUN, HOLD, DRAIN} state_t;
  state_t state, state_nx;
  logic [1:0] lat, lat_nx, req, eff, pc_i;
  logic [DW-1:0] cnt, cnt_nx;
  logic [STAGES-1:0] flush_i;
  logic stall_i;
  // Redirect kinds are encoded as their pc_sel value; rank restores exc > branch > jump.
  function automatic logic [1:0] rank(input logic [1:0] k);
    return k == K_EXC ? 2'd3 : k == K_BR ? 2'd2 : k == K_JMP ? 2'd1 : 2'd0;
  endfunction
  function automatic logic [STAGES-1:0] fmask(input logic [1:0] k);
    return k == K_EXC ? ALL : k == K_BR ? BR_M : k == K_JMP ? JMP_M : '0;
  endfunction
  assign req = exc_req ? K_EXC : branch_taken ? K_BR : jump ? K_JMP : K_NONE;
  assign eff = rank(req) > rank(lat) ? req : lat;
  always_comb begin
    state_nx = state;
    lat_nx   = lat;
    cnt_nx   = cnt;
    flush_i  = '0;
    stall_i  = 1'b0;
    pc_i     = K_NONE;
    case (state)
      RUN: begin
        if (mem_busy) begin
          lat_nx   = req;
          state_nx = req != K_NONE ? HOLD : RUN;
        end else if (req != K_NONE) begin
          pc_i    = req;
          flush_i = fmask(req);
          if (req == K_EXC) begin
            state_nx = DRAIN;
            cnt_nx   = DW'(DRAIN_CYC);
          end
        end else if (load_use) begin
          stall_i = 1'b1;
          flush_i = BUBBLE;
        end
      end
      HOLD: begin
        if (mem_busy) lat_nx = eff;
        else begin
          pc_i     = eff;
          flush_i  = fmask(eff);
          lat_nx   = K_NONE;
          state_nx = eff == K_EXC ? DRAIN : RUN;
          cnt_nx   = eff == K_EXC ? DW'(DRAIN_CYC) : cnt;
        end
      end
      DRAIN: begin
        flush_i = ALL;
        stall_i = 1'b1;
        if (exc_req) begin
          pc_i   = K_EXC;
          cnt_nx = DW'(DRAIN_CYC);
        end else if (!mem_busy) begin
          if (cnt == DW'(1)) state_nx = RUN;
          else cnt_nx = cnt - DW'(1);
        end
      end
      default: state_nx = RUN;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      lat         <= K_NONE;
      cnt         <= '0;
      flush_count <= '0;
    end else begin
      state <= state_nx;
      lat   <= lat_nx;
      cnt   <= cnt_nx;
      if (cnt_clr) flush_count <= '0;
      else if (pc_i != K_NONE && !(&flush_count)) flush_count <= flush_count + CNT_W'(1);
    end
  end
  assign flush       = rst_n ? flush_i : '0;
  assign stall_front = rst_n & stall_i;
  assign pc_sel      = rst_n ? pc_i : K_NONE;
  assign busy        = rst_n && state != RUN;
endmodule
